// File: rtl/gh_uart_tx_fifo.sv
// 16550 TX holding stage: DEPTH-entry FWFT queue (1 entry in 16450 mode) plus THRE/TEMT status and THRE interrupt.
// Latency: byte written at edge N is on D with D_RYn=0 after edge N; pop advances D after the read edge.
// Backpressure: writes when full are dropped (ovf pulse only with GH_UART_TX_FIFO_OVF_EN); reads when empty are ignored.
module gh_uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           wd,
    input  logic                       fifo_en,
    input  logic                       fifo_clr,
    input  logic                       read,
    input  logic                       tx_busyn,
    input  logic                       thre_ack,
    output logic [WIDTH-1:0]           D,
    output logic                       D_RYn,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       thre,
    output logic                       temt,
    output logic                       thre_int,
    output logic                       ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP_FIFO = DEPTH[AW:0];
    localparam logic [AW:0] CAP_REG  = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_nxt;
    logic [AW:0]      cap;
    logic             fifo_en_q;
    logic             flush;
    logic             pop;
    logic             push;
    logic             empty_set;

    assign cap   = fifo_en ? CAP_FIFO : CAP_REG;
    // A mode change between FIFO and 16450 behaves exactly like an FCR flush.
    assign flush = fifo_clr | (fifo_en != fifo_en_q);
    assign pop   = read & (cnt_q != '0) & ~flush;
    // A full queue still accepts a write when the serializer pops in the same cycle.
    assign push  = wr & ~flush & ((cnt_q < cap) | ((cnt_q == cap) & pop));

    always_comb begin
        cnt_nxt = cnt_q;
        if (flush)
            cnt_nxt = '0;
        else if (push && !pop)
            cnt_nxt = cnt_q + 1'b1;
        else if (pop && !push)
            cnt_nxt = cnt_q - 1'b1;
    end

    assign empty_set = (cnt_q != '0) && (cnt_nxt == '0);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt_q     <= '0;
            fifo_en_q <= fifo_en;
            thre_int  <= 1'b0;
        end else begin
            fifo_en_q <= fifo_en;
            cnt_q     <= cnt_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end
            // Going empty outranks a same-cycle acknowledge or push.
            if (empty_set)
                thre_int <= 1'b1;
            else if (thre_ack || push)
                thre_int <= 1'b0;
        end
    end

`ifdef GH_UART_TX_FIFO_OVF_EN
    logic drop;
    logic ovf_q;

    assign drop = wr & ~flush & ~push;

    always_ff @(posedge clk) begin
        if (rst)
            ovf_q <= 1'b0;
        else
            ovf_q <= drop;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign D     = mem[rd_ptr];
    assign count = cnt_q;
    assign D_RYn = (cnt_q == '0);
    assign thre  = (cnt_q == '0);
    assign full  = (cnt_q == cap);
    assign temt  = thre & tx_busyn;

endmodule

// File: tb/tb_gh_uart_tx_fifo.sv
// Directed bench for gh_uart_tx_fifo: reset, FWFT, full/drop, simultaneous push/pop, 16450 mode, flush, TEMT.
module tb_gh_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] wd;
    logic       fifo_en;
    logic       fifo_clr;
    logic       read;
    logic       tx_busyn;
    logic       thre_ack;
    logic [7:0] D;
    logic       D_RYn;
    logic [4:0] count;
    logic       full;
    logic       thre;
    logic       temt;
    logic       thre_int;
    logic       ovf;

    int passed = 0;
    int total  = 0;

`ifdef GH_UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    gh_uart_tx_fifo #(.DEPTH(16), .WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .wd       (wd),
        .fifo_en  (fifo_en),
        .fifo_clr (fifo_clr),
        .read     (read),
        .tx_busyn (tx_busyn),
        .thre_ack (thre_ack),
        .D        (D),
        .D_RYn    (D_RYn),
        .count    (count),
        .full     (full),
        .thre     (thre),
        .temt     (temt),
        .thre_int (thre_int),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr = 1'b1;
        wd = b;
        step();
        wr = 1'b0;
    endtask

    task automatic pop_byte();
        read = 1'b1;
        step();
        read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL reset_count got %0d exp 0", count); else passed++;
        total++; if (D_RYn !== 1'b1) $display("FAIL reset_dryn got %b exp 1", D_RYn); else passed++;
        total++; if (thre !== 1'b1) $display("FAIL reset_thre got %b exp 1", thre); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b exp 0", full); else passed++;
        total++; if (thre_int !== 1'b0) $display("FAIL reset_thre_int got %b exp 0", thre_int); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf); else passed++;
        total++; if (temt !== 1'b1) $display("FAIL reset_temt got %b exp 1", temt); else passed++;
    endtask

    task automatic test_single();
        push_byte(8'h41);
        total++; if (D_RYn !== 1'b0) $display("FAIL single_dryn got %b exp 0", D_RYn); else passed++;
        total++; if (D !== 8'h41) $display("FAIL single_d got %h exp 41", D); else passed++;
        total++; if (count !== 5'd1) $display("FAIL single_count got %0d exp 1", count); else passed++;
        total++; if (thre !== 1'b0) $display("FAIL single_thre got %b exp 0", thre); else passed++;
        // Pop to empty together with thre_ack: setting wins.
        thre_ack = 1'b1;
        pop_byte();
        thre_ack = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL single_pop_count got %0d exp 0", count); else passed++;
        total++; if (thre !== 1'b1) $display("FAIL single_pop_thre got %b exp 1", thre); else passed++;
        total++; if (thre_int !== 1'b1) $display("FAIL single_thre_int got %b exp 1", thre_int); else passed++;
        thre_ack = 1'b1;
        step();
        thre_ack = 1'b0;
        total++; if (thre_int !== 1'b0) $display("FAIL single_ack got %b exp 0", thre_int); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) push_byte(8'(i));
        total++; if (full !== 1'b1) $display("FAIL full_flag got %b exp 1", full); else passed++;
        total++; if (count !== 5'd16) $display("FAIL full_count got %0d exp 16", count); else passed++;
        push_byte(8'h55);
        total++; if (ovf !== OVF_EXP) $display("FAIL full_ovf got %b exp %b", ovf, OVF_EXP); else passed++;
        total++; if (count !== 5'd16) $display("FAIL full_drop_count got %0d exp 16", count); else passed++;
        step();
        total++; if (ovf !== 1'b0) $display("FAIL full_ovf_end got %b exp 0", ovf); else passed++;
        for (int i = 0; i < 16; i++) begin
            total++; if (D !== 8'(i)) $display("FAIL full_order[%0d] got %h exp %h", i, D, 8'(i)); else passed++;
            pop_byte();
        end
        total++; if (count !== 5'd0) $display("FAIL full_drain_count got %0d exp 0", count); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        wr = 1'b1; wd = 8'hAA; read = 1'b1;
        step();
        wr = 1'b0; read = 1'b0;
        total++; if (count !== 5'd16) $display("FAIL b2b_full_count got %0d exp 16", count); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL b2b_ovf got %b exp 0", ovf); else passed++;
        for (int i = 1; i < 16; i++) begin
            total++; if (D !== 8'h10 + 8'(i)) $display("FAIL b2b_order[%0d] got %h exp %h", i, D, 8'h10 + 8'(i)); else passed++;
            pop_byte();
        end
        total++; if (D !== 8'hAA) $display("FAIL b2b_last got %h exp aa", D); else passed++;
        pop_byte();
        total++; if (count !== 5'd0) $display("FAIL b2b_drain got %0d exp 0", count); else passed++;
        wr = 1'b1; wd = 8'h77; read = 1'b1;
        step();
        wr = 1'b0; read = 1'b0;
        total++; if (count !== 5'd1) $display("FAIL b2b_empty_count got %0d exp 1", count); else passed++;
        total++; if (D !== 8'h77) $display("FAIL b2b_empty_d got %h exp 77", D); else passed++;
        pop_byte();
        thre_ack = 1'b1;
        step();
        thre_ack = 1'b0;
    endtask

    task automatic test_16450();
        fifo_en = 1'b0;
        step();
        push_byte(8'h11);
        total++; if (full !== 1'b1) $display("FAIL m16450_full got %b exp 1", full); else passed++;
        push_byte(8'h22);
        total++; if (ovf !== OVF_EXP) $display("FAIL m16450_ovf got %b exp %b", ovf, OVF_EXP); else passed++;
        total++; if (count !== 5'd1) $display("FAIL m16450_count got %0d exp 1", count); else passed++;
        total++; if (D !== 8'h11) $display("FAIL m16450_d got %h exp 11", D); else passed++;
        fifo_en = 1'b1;
        step();
        total++; if (count !== 5'd0) $display("FAIL m16450_toggle_count got %0d exp 0", count); else passed++;
        total++; if (thre_int !== 1'b1) $display("FAIL m16450_toggle_int got %b exp 1", thre_int); else passed++;
    endtask

    task automatic test_flush();
        thre_ack = 1'b1;
        step();
        thre_ack = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        total++; if (count !== 5'd5) $display("FAIL flush_pre_count got %0d exp 5", count); else passed++;
        fifo_clr = 1'b1; wr = 1'b1; wd = 8'h99;
        step();
        fifo_clr = 1'b0; wr = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL flush_count got %0d exp 0", count); else passed++;
        total++; if (thre !== 1'b1) $display("FAIL flush_thre got %b exp 1", thre); else passed++;
        total++; if (thre_int !== 1'b1) $display("FAIL flush_thre_int got %b exp 1", thre_int); else passed++;
        thre_ack = 1'b1;
        step();
        thre_ack = 1'b0;
        total++; if (thre_int !== 1'b0) $display("FAIL flush_ack got %b exp 0", thre_int); else passed++;
        // Pointers restart at 0 after the flush.
        push_byte(8'h3C);
        total++; if (D !== 8'h3C) $display("FAIL flush_after_d got %h exp 3c", D); else passed++;
        pop_byte();
    endtask

    task automatic test_temt();
        tx_busyn = 1'b0;
        #1;
        total++; if (temt !== 1'b0) $display("FAIL temt_busy got %b exp 0", temt); else passed++;
        tx_busyn = 1'b1;
        #1;
        total++; if (temt !== 1'b1) $display("FAIL temt_idle got %b exp 1", temt); else passed++;
        push_byte(8'h01);
        total++; if (temt !== 1'b0) $display("FAIL temt_queued got %b exp 0", temt); else passed++;
    endtask

    task automatic test_reset_mid();
        push_byte(8'h02);
        push_byte(8'h03);
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (count !== 5'd0) $display("FAIL rstmid_count got %0d exp 0", count); else passed++;
        total++; if (thre_int !== 1'b0) $display("FAIL rstmid_thre_int got %b exp 0", thre_int); else passed++;
    endtask

    initial begin
        rst = 1'b1; wr = 1'b0; wd = 8'h00; fifo_en = 1'b1; fifo_clr = 1'b0;
        read = 1'b0; tx_busyn = 1'b1; thre_ack = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_16450();
        test_flush();
        test_temt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
